// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with a one-entry skid buffer and valid/ready handshake.
// Optional fetch-address exception flag compiled in with IF_ID_ADEL_CHECK_EN.
module if_id_skid_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pcplus,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus,
  output logic        out_adel
);

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] skid_pcplus;
  logic        accept;
  logic        drain;
  logic [31:0] load_instr;

  // Ready comes straight off the skid flop, so fetch never sees out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

`ifdef IF_ID_ADEL_CHECK_EN
  logic in_flag;
  logic main_adel;
  logic skid_adel;

  assign in_flag    = (in_pc[1:0] != 2'b00) | (in_pc < 32'h0000_3000) | (in_pc > 32'h0000_6FFC);
  assign load_instr = in_flag ? '0 : in_instr;
  assign out_adel   = main_adel;
`else
  assign load_instr = in_instr;
  assign out_adel   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      out_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      out_instr   <= '0;
      out_pc      <= RESET_PC;
      out_pcplus  <= RESET_PC + 32'd4;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_pcplus <= '0;
`ifdef IF_ID_ADEL_CHECK_EN
      main_adel   <= 1'b0;
      skid_adel   <= 1'b0;
`endif
    end else if (skid_valid && (!out_valid || drain)) begin
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
      out_instr  <= skid_instr;
      out_pc     <= skid_pc;
      out_pcplus <= skid_pcplus;
`ifdef IF_ID_ADEL_CHECK_EN
      main_adel  <= skid_adel;
`endif
    end else if (accept && (!out_valid || drain)) begin
      out_valid  <= 1'b1;
      out_instr  <= load_instr;
      out_pc     <= in_pc;
      out_pcplus <= in_pcplus;
`ifdef IF_ID_ADEL_CHECK_EN
      main_adel  <= in_flag;
`endif
    end else if (accept && out_valid && !out_ready) begin
      skid_valid  <= 1'b1;
      skid_instr  <= load_instr;
      skid_pc     <= in_pc;
      skid_pcplus <= in_pcplus;
`ifdef IF_ID_ADEL_CHECK_EN
      skid_adel   <= in_flag;
`endif
    end else if (drain) begin
      // Data registers keep the last packet; only the valid bit drops.
      out_valid <= 1'b0;
    end
  end

endmodule
